seq_gen: RTL and testbench
==========================

SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter PATTERN, default 4'b1011: the bit pattern transmitted, MSB first.
REQ-002 SHALL have parameter PAT_LEN, default 4: pattern length in bits (2..8).
REQ-003 SHALL have parameter OVL_LEN, default 3: bits sent per repeat in overlap mode (the suffix after the shared prefix).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: the reset, synchronous and active-low (0 = reset).
REQ-006 SHALL have port start, input, 1 bit: request to begin a burst, sampled only in IDLE.
REQ-007 SHALL have port repeat_cnt, input, 4 bits: burst holds repeat_cnt+1 patterns, latched at start.
REQ-008 SHALL have port gap, input, 4 bits: number of 0 filler bits between patterns, latched at start.
REQ-009 SHALL have port overlap_en, input, 1 bit: when 1, repeats reuse the trailing bit(s) of the previous pattern; latched at start.
REQ-010 SHALL have port abort, input, 1 bit: terminates the burst immediately.
REQ-011 SHALL have port dout, output, 1 bit: serial data, registered.
REQ-012 SHALL have port dout_valid, output, 1 bit: dout carries a stream bit (pattern or gap).
REQ-013 SHALL have port match, output, 1 bit: high coincident with the last bit of each complete pattern.
REQ-014 SHALL have port busy, output, 1 bit: a burst is in progress.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after a burst completes normally.

Function
REQ-016 SHALL implement the states IDLE, SEND, GAP and FIN.
REQ-017 IDLE with start=1 at edge k SHALL latch the inputs, enter SEND, and drive the first pattern bit on dout with dout_valid=1 and busy=1 during cycle k+1.
REQ-018 SEND SHALL emit one bit per cycle, MSB first.
- First pattern: all PAT_LEN bits.
- Later patterns: all PAT_LEN bits when overlap_en=0; only the low OVL_LEN bits when overlap_en=1.
REQ-019 match SHALL be 1 during the cycle the last bit of each pattern is on dout, and 0 otherwise.
REQ-020 After a pattern with patterns remaining, SEND SHALL go to GAP if gap>0 and overlap_en=0; otherwise it SHALL continue in SEND.
REQ-021 GAP SHALL emit gap cycles of dout=0 with dout_valid=1, then return to SEND.
REQ-022 When overlap_en=1, gap SHALL be ignored.
REQ-023 After the last bit of the final pattern, the FSM SHALL enter FIN: done=1 for one cycle, busy=0, dout_valid=0, then IDLE.
REQ-024 Whenever dout_valid=0, dout SHALL be 0.
REQ-025 start SHALL be ignored while busy=1 or in FIN; a new start is accepted in IDLE only.
REQ-026 abort=1 at any edge SHALL force IDLE on that edge: next cycle busy, dout_valid, dout, match and done are all 0, and no done pulse is produced.
REQ-027 abort takes priority over start and over a burst end on the same edge.
REQ-028 The internal bit and gap counters SHALL be at least clog2(PAT_LEN+1) and 4 bits wide; the repeat counter SHALL be 4 bits and SHALL NOT wrap (repeat_cnt=15 gives 16 patterns).

Reset
REQ-029 With rst=0 at a clock edge, the state SHALL become IDLE and dout, dout_valid, match, busy and done SHALL all be 0 on the next cycle.
REQ-030 rst=0 mid-burst SHALL discard the burst without a done pulse.
REQ-031 rst SHALL have priority over abort and start.

Structure
REQ-032 Package seq_gen_pkg SHALL hold the state enum (IDLE, SEND, GAP, FIN), the default PATTERN/PAT_LEN/OVL_LEN constants and the counter widths.
REQ-033 The block SHALL be a single module with no sub-modules; the FSM, shift register and counters are all in seq_gen.

Verification
REQ-034 Reset: rst=0 for 3 cycles with start=1 -> all outputs 0, no burst; release -> IDLE.
REQ-035 Single pattern: start, repeat_cnt=0, gap=0, overlap_en=0 -> dout 1,0,1,1 in cycles k+1..k+4; match only at k+4; done at k+5; busy k+1..k+4.
REQ-036 Overlap: repeat_cnt=2, overlap_en=1 -> dout 1011011011 over 10 cycles; match at bits 4, 7, 10; done at bit 11.
REQ-037 Gap: repeat_cnt=1, gap=2, overlap_en=0 -> dout 1011 00 1011; dout_valid high for 10 cycles; match at bits 4 and 10.
REQ-038 Abort/restart: abort at bit 3 -> following cycle all outputs 0, no done; start held high during busy has no effect, and is accepted in IDLE.
REQ-039 Loopback: dout, gated by dout_valid, feeds the team's 1011 overlapping detector -> detector y asserts at exactly the cycles where match=1 in REQ-036 and REQ-037.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern burst generator.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
  localparam int         DEF_PAT_LEN = 4;
  localparam int         DEF_OVL_LEN = 3;

  localparam int REP_W = 4;
  localparam int GAP_W = 4;

  // Bit counter must hold PAT_LEN and is never narrower than 4 bits.
  function automatic int cnt_width(input int len);
    int w;
    w = $clog2(len + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/seq_gen.sv
// Serial burst generator: repeats a fixed bit pattern with optional zero gaps
// or prefix-sharing overlap, flagging the last bit of each complete pattern.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter logic [7:0] PATTERN = DEF_PATTERN,
  parameter int         PAT_LEN = DEF_PAT_LEN,
  parameter int         OVL_LEN = DEF_OVL_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [REP_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap,
  input  logic             overlap_en,
  input  logic             abort,
  output logic             dout,
  output logic             dout_valid,
  output logic             match,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_width(PAT_LEN);

  // Patterns are left-justified in the shift register so bit 7 is always next.
  localparam logic [7:0] PAT_ALIGNED = PATTERN << (8 - PAT_LEN);
  localparam logic [7:0] PAT_REST    = PAT_ALIGNED << 1;
  localparam logic [7:0] OVL_ALIGNED = PATTERN << (8 - OVL_LEN);
  localparam logic [7:0] OVL_REST    = OVL_ALIGNED << 1;

  state_t           state;
  logic [7:0]       shreg;
  logic [CNT_W-1:0] bits_left;
  logic [REP_W-1:0] rep_left;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_left;
  logic             ovl_q;

  // NOTE: every register here, including the latched burst settings, is reset;
  // non-blocking assignments keep all next-state values based on this cycle's state.
  always_ff @(posedge clk) begin
    if (!rst || abort) begin
      state      <= IDLE;
      shreg      <= '0;
      bits_left  <= '0;
      rep_left   <= '0;
      gap_q      <= '0;
      gap_left   <= '0;
      ovl_q      <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      match      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      match <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
          if (start) begin
            rep_left   <= repeat_cnt;
            gap_q      <= gap;
            ovl_q      <= overlap_en;
            state      <= SEND;
            dout       <= PAT_ALIGNED[7];
            shreg      <= PAT_REST;
            bits_left  <= CNT_W'(PAT_LEN - 1);
            dout_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end

        SEND: begin
          if (bits_left != '0) begin
            dout      <= shreg[7];
            shreg     <= shreg << 1;
            bits_left <= bits_left - 1'b1;
            match     <= (bits_left == CNT_W'(1));
          end else if (rep_left == '0) begin
            state      <= FIN;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            rep_left <= rep_left - 1'b1;
            if (ovl_q) begin
              dout      <= OVL_ALIGNED[7];
              shreg     <= OVL_REST;
              bits_left <= CNT_W'(OVL_LEN - 1);
              match     <= (OVL_LEN == 1);
            end else if (gap_q != '0) begin
              state    <= GAP;
              gap_left <= gap_q - 1'b1;
              dout     <= 1'b0;
            end else begin
              dout      <= PAT_ALIGNED[7];
              shreg     <= PAT_REST;
              bits_left <= CNT_W'(PAT_LEN - 1);
            end
          end
        end

        GAP: begin
          if (gap_left != '0) begin
            gap_left <= gap_left - 1'b1;
            dout     <= 1'b0;
          end else begin
            state     <= SEND;
            dout      <= PAT_ALIGNED[7];
            shreg     <= PAT_REST;
            bits_left <= CNT_W'(PAT_LEN - 1);
          end
        end

        FIN: begin
          state      <= IDLE;
          dout       <= 1'b0;
          dout_valid <= 1'b0;
          busy       <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: directed bursts, abort/reset cases and
// randomized bursts against a stream-building reference model.
module tb_seq_gen;

  localparam logic [7:0] PATTERN = 8'b0000_1011;
  localparam int         PAT_LEN = 4;
  localparam int         OVL_LEN = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] repeat_cnt;
  logic [3:0] gap;
  logic       overlap_en;
  logic       abort;
  logic       dout;
  logic       dout_valid;
  logic       match;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  // Loopback 1011 overlapping detector fed by dout gated with dout_valid.
  logic [2:0] det_hist = 3'b000;
  logic       det_y;
  assign det_y = ({det_hist, dout & dout_valid} == 4'b1011);
  always @(posedge clk) det_hist <= {det_hist[1:0], dout & dout_valid};

  seq_gen #(.PATTERN(PATTERN), .PAT_LEN(PAT_LEN), .OVL_LEN(OVL_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .overlap_en (overlap_en),
    .abort      (abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .match      (match),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b want %b (dout,valid,match,busy,done)", tag, obs, exp);
    end
  endtask

  task automatic check_det(input string tag, input logic exp);
    tests++;
    assert (det_y === exp) else begin
      fails++;
      $error("FAIL %s: detector y got %b want %b", tag, det_y, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {dout, dout_valid, match, busy, done};
  endfunction

  // Runs one burst from IDLE; returns with the bench in the idle cycle after done.
  task automatic run_burst(input int rep, input int gp, input bit ovl,
                           input bit det, input bit hold);
    bit q_d[$];
    bit q_m[$];
    for (int p = 0; p <= rep; p++) begin
      int n;
      n = (p == 0 || !ovl) ? PAT_LEN : OVL_LEN;
      for (int b = n - 1; b >= 0; b--) begin
        q_d.push_back(PATTERN[b]);
        q_m.push_back(b == 0);
      end
      if (p < rep && !ovl)
        for (int g = 0; g < gp; g++) begin
          q_d.push_back(1'b0);
          q_m.push_back(1'b0);
        end
    end
    start      = 1'b1;
    repeat_cnt = 4'(rep);
    gap        = 4'(gp);
    overlap_en = ovl;
    step();
    if (!hold) start = 1'b0;
    repeat_cnt = 4'($urandom);
    gap        = 4'($urandom);
    overlap_en = 1'($urandom);
    for (int i = 0; i < q_d.size(); i++) begin
      check($sformatf("bit%0d", i), outs(), {q_d[i], 1'b1, q_m[i], 1'b1, 1'b0});
      if (det) check_det($sformatf("det%0d", i), q_m[i]);
      step();
    end
    check("done_pulse", outs(), 5'b00001);
    step();
    check("post_idle", outs(), 5'b00000);
  endtask

  initial begin
    rst = 1'b0; start = 1'b1; abort = 1'b0;
    repeat_cnt = 4'd0; gap = 4'd0; overlap_en = 1'b0;

    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_hold", outs(), 5'b00000);
    end
    start = 1'b0;
    rst   = 1'b1;
    step();
    check("reset_release", outs(), 5'b00000);

    run_burst(0, 0, 1'b0, 1'b0, 1'b0);
    run_burst(2, 0, 1'b1, 1'b1, 1'b0);
    run_burst(1, 2, 1'b0, 1'b1, 1'b0);
    run_burst(2, 5, 1'b1, 1'b0, 1'b0);
    run_burst(15, 0, 1'b0, 1'b0, 1'b0);

    // start held through the burst and FIN; taken again once back in IDLE.
    run_burst(1, 1, 1'b0, 1'b0, 1'b1);
    step();
    check("restart_accept", outs(), 5'b11010);
    abort = 1'b1;
    start = 1'b0;
    step();
    check("restart_abort", outs(), 5'b00000);
    abort = 1'b0;

    // Abort during bit 3 of a multi-pattern burst.
    start = 1'b1; repeat_cnt = 4'd3; gap = 4'd0; overlap_en = 1'b0;
    step();
    start = 1'b0;
    check("ab_bit1", outs(), 5'b11010);
    step();
    check("ab_bit2", outs(), 5'b01010);
    step();
    check("ab_bit3", outs(), 5'b11010);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_after", outs(), 5'b00000);
    for (int i = 0; i < 6; i++) begin
      step();
      check("ab_quiet", outs(), 5'b00000);
    end

    // abort wins over start on the same edge.
    start = 1'b1; abort = 1'b1;
    step();
    check("ab_vs_start", outs(), 5'b00000);
    abort = 1'b0; start = 1'b0;

    // Reset mid-burst, with abort and start also high, discards the burst.
    start = 1'b1; repeat_cnt = 4'd2;
    step();
    start = 1'b0;
    step();
    rst = 1'b0; abort = 1'b1; start = 1'b1;
    step();
    check("rst_mid", outs(), 5'b00000);
    rst = 1'b1; abort = 1'b0; start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_quiet", outs(), 5'b00000);
    end

    for (int t = 0; t < 25; t++)
      run_burst(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                1'($urandom), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
